// File: rtl/sd_pkg.sv
// Shared sigma-delta parameters and helpers, used by this front end and the CIC block.
package sd_pkg;

  localparam int DECIM_RATIO_DEF = 64;
  localparam int OVL_LEN_DEF     = 256;

  // Width needed to hold a full-window ones count (0..ratio inclusive).
  function automatic int ones_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/sd_sync2.sv
// Two-flop synchroniser with asynchronous reset; exposes both stages so a
// caller can derive a second flop in parallel with the output stage.
module sd_sync2 (
  input  logic adc_clk,
  input  logic reset,
  input  logic d,
  output logic stage1,
  output logic q
);

  // Capture the asynchronous input, then re-time it once more.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      stage1 <= 1'b0;
      q      <= 1'b0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/sd_modulator_frontend.sv
// Sigma-delta modulator front end: comparator synchroniser, feedback DAC drive,
// decimation clock, per-window ones count and stuck-bit overload detection.
module sd_modulator_frontend
  import sd_pkg::*;
#(
  parameter int DECIM_RATIO = DECIM_RATIO_DEF,
  parameter int OVL_LEN     = OVL_LEN_DEF,
  parameter bit FB_INVERT   = 1'b1
) (
  input  logic                               adc_clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               comp_in,
  input  logic                               clr_ovl,
  output logic                               sigma_delta_out,
  output logic                               fb_out,
  output logic                               decimation_clk,
  output logic [ones_width(DECIM_RATIO)-1:0] ones_count,
  output logic                               ones_valid,
  output logic                               overload,
  output logic                               ovl_sticky
);

  localparam int CNT_W = $clog2(DECIM_RATIO);
  localparam int CW    = ones_width(DECIM_RATIO);
  localparam int RUN_W = $clog2(OVL_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM_RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DECIM_RATIO / 2);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(OVL_LEN);

  logic             sync1_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CW-1:0]    acc_r;
  logic [CW-1:0]    ones_sum_s;
  logic [RUN_W-1:0] run_r;
  logic [RUN_W-1:0] run_next_s;
  logic             prev_r;
  logic             wrap_s;
  logic             ovl_next_s;

  sd_sync2 u_sync (
    .adc_clk (adc_clk),
    .reset   (reset),
    .d       (comp_in),
    .stage1  (sync1_s),
    .q       (sigma_delta_out)
  );

  // Feedback drive is its own flop so it resets to 0 even when inverted.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      fb_out <= 1'b0;
    end else begin
      fb_out <= sync1_s ^ FB_INVERT;
    end
  end

  // Next-state terms for window counter, accumulator and run detector.
  always_comb begin
    wrap_s     = (cnt_r == CNT_LAST);
    cnt_next_s = wrap_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
    ones_sum_s = acc_r + CW'(sigma_delta_out);
    if (sigma_delta_out != prev_r) begin
      run_next_s = RUN_W'(1);
    end else if (run_r >= RUN_MAX) begin
      run_next_s = RUN_MAX;
    end else begin
      run_next_s = run_r + RUN_W'(1);
    end
    ovl_next_s = enable && (run_next_s >= RUN_MAX);
  end

  // Window, ones-count and run-length state; disabling restarts from the reset state.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      cnt_r          <= {CNT_W{1'b0}};
      acc_r          <= {CW{1'b0}};
      run_r          <= {RUN_W{1'b0}};
      prev_r         <= 1'b0;
      decimation_clk <= 1'b0;
      ones_count     <= {CW{1'b0}};
      ones_valid     <= 1'b0;
      overload       <= 1'b0;
    end else if (!enable) begin
      cnt_r          <= {CNT_W{1'b0}};
      acc_r          <= {CW{1'b0}};
      run_r          <= {RUN_W{1'b0}};
      prev_r         <= 1'b0;
      decimation_clk <= 1'b0;
      ones_valid     <= 1'b0;
      overload       <= 1'b0;
    end else begin
      cnt_r          <= cnt_next_s;
      decimation_clk <= (cnt_next_s < CNT_HALF);
      prev_r         <= sigma_delta_out;
      run_r          <= run_next_s;
      overload       <= ovl_next_s;
      if (wrap_s) begin
        ones_count <= ones_sum_s;
        acc_r      <= {CW{1'b0}};
        ones_valid <= 1'b1;
      end else begin
        acc_r      <= ones_sum_s;
        ones_valid <= 1'b0;
      end
    end
  end

  // Latched overload; a new overload beats a simultaneous clear.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      ovl_sticky <= 1'b0;
    end else if (ovl_next_s) begin
      ovl_sticky <= 1'b1;
    end else if (clr_ovl) begin
      ovl_sticky <= 1'b0;
    end else begin
      ovl_sticky <= ovl_sticky;
    end
  end

endmodule

// File: tb/tb_sd_modulator_frontend.sv
// Directed bench for sd_modulator_frontend with DECIM_RATIO=64, OVL_LEN=256, FB_INVERT=1.
module tb_sd_modulator_frontend;

  logic       adc_clk = 1'b0;
  logic       reset, enable, comp_in, clr_ovl;
  logic       sigma_delta_out, fb_out, decimation_clk, ones_valid, overload, ovl_sticky;
  logic [6:0] ones_count;

  int n_tests = 0;
  int n_fail  = 0;
  int e;

  typedef struct {
    int   edge_n;
    logic dclk;
    logic valid;
    int   count;
    logic ovl;
    logic sticky;
  } chk_t;

  chk_t tbl[12];

  sd_modulator_frontend #(.DECIM_RATIO(64), .OVL_LEN(256), .FB_INVERT(1'b1)) dut (
    .adc_clk         (adc_clk),
    .reset           (reset),
    .enable          (enable),
    .comp_in         (comp_in),
    .clr_ovl         (clr_ovl),
    .sigma_delta_out (sigma_delta_out),
    .fb_out          (fb_out),
    .decimation_clk  (decimation_clk),
    .ones_count      (ones_count),
    .ones_valid      (ones_valid),
    .overload        (overload),
    .ovl_sticky      (ovl_sticky)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  initial begin
    int valids;
    int ovls;

    // Constant-ones schedule, counted in enabled edges.
    tbl[0]  = '{1,   1'b1, 1'b0, 0,  1'b0, 1'b0};
    tbl[1]  = '{31,  1'b1, 1'b0, 0,  1'b0, 1'b0};
    tbl[2]  = '{32,  1'b0, 1'b0, 0,  1'b0, 1'b0};
    tbl[3]  = '{63,  1'b0, 1'b0, 0,  1'b0, 1'b0};
    tbl[4]  = '{64,  1'b1, 1'b1, 64, 1'b0, 1'b0};
    tbl[5]  = '{65,  1'b1, 1'b0, 64, 1'b0, 1'b0};
    tbl[6]  = '{96,  1'b0, 1'b0, 64, 1'b0, 1'b0};
    tbl[7]  = '{128, 1'b1, 1'b1, 64, 1'b0, 1'b0};
    tbl[8]  = '{255, 1'b0, 1'b0, 64, 1'b0, 1'b0};
    tbl[9]  = '{256, 1'b1, 1'b1, 64, 1'b1, 1'b1};
    tbl[10] = '{300, 1'b0, 1'b0, 64, 1'b1, 1'b1};
    tbl[11] = '{320, 1'b1, 1'b1, 64, 1'b1, 1'b1};

    reset = 1'b1; enable = 1'b0; comp_in = 1'b1; clr_ovl = 1'b0;
    tick(); tick();
    check("rst_sdo", sigma_delta_out, 0);
    check("rst_fb", fb_out, 0);
    check("rst_dclk", decimation_clk, 0);
    check("rst_valid", ones_valid, 0);
    check("rst_count", ones_count, 0);
    check("rst_ovl", overload, 0);
    check("rst_sticky", ovl_sticky, 0);

    // Synchroniser runs while disabled; comp_in appears on the 2nd edge.
    reset = 1'b0;
    tick();
    check("sync_edge1_sdo", sigma_delta_out, 0);
    tick();
    check("sync_edge2_sdo", sigma_delta_out, 1);
    check("sync_edge2_fb", fb_out, 0);
    check("dis_dclk", decimation_clk, 0);

    enable = 1'b1;
    e = 0;
    for (int i = 0; i < 12; i++) begin
      while (e < tbl[i].edge_n) begin
        tick();
        e++;
      end
      check($sformatf("tbl%0d_dclk", i), decimation_clk, tbl[i].dclk);
      check($sformatf("tbl%0d_valid", i), ones_valid, tbl[i].valid);
      check($sformatf("tbl%0d_count", i), ones_count, tbl[i].count);
      check($sformatf("tbl%0d_ovl", i), overload, tbl[i].ovl);
      check($sformatf("tbl%0d_sticky", i), ovl_sticky, tbl[i].sticky);
    end

    // Alternating bitstream: 32 ones per window, never overloaded.
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      comp_in = ~comp_in;
    end
    enable = 1'b1;
    e = 0;
    ovls = 0;
    while (e < 200) begin
      tick();
      comp_in = ~comp_in;
      e++;
      if (overload) ovls++;
      if (e == 64 || e == 128 || e == 192) begin
        check($sformatf("toggle_valid_e%0d", e), ones_valid, 1);
        check($sformatf("toggle_count_e%0d", e), ones_count, 32);
      end
    end
    check("toggle_no_ovl", ovls, 0);

    // Reset mid-window at cnt=40.
    comp_in = 1'b1;
    while (e % 64 != 40) begin
      tick();
      e++;
    end
    reset = 1'b1;
    #2;
    check("midrst_sdo", sigma_delta_out, 0);
    check("midrst_count", ones_count, 0);
    check("midrst_dclk", decimation_clk, 0);
    check("midrst_valid", ones_valid, 0);
    tick();
    reset = 1'b0; enable = 1'b0;
    tick(); tick();
    enable = 1'b1;
    e = 0;
    valids = 0;
    while (e < 63) begin
      tick();
      e++;
      if (ones_valid) valids++;
    end
    check("postrst_early_valid", valids, 0);
    tick();
    e++;
    check("postrst_valid", ones_valid, 1);
    check("postrst_count", ones_count, 64);

    // Drop enable for 10 cycles mid-window.
    while (e < 84) begin
      tick();
      e++;
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold%0d_dclk", i), decimation_clk, 0);
      check($sformatf("hold%0d_valid", i), ones_valid, 0);
      check($sformatf("hold%0d_ovl", i), overload, 0);
      check($sformatf("hold%0d_count", i), ones_count, 64);
    end
    enable = 1'b1;
    e = 0;
    tick();
    e++;
    check("reen_dclk", decimation_clk, 1);
    while (e < 64) begin
      tick();
      e++;
    end
    check("reen_valid_e64", ones_valid, 1);

    // Overload with clr_ovl held: set wins, then clear after run breaks.
    while (e < 255) begin
      tick();
      e++;
    end
    check("clr_pre_ovl", overload, 0);
    check("clr_pre_sticky", ovl_sticky, 0);
    clr_ovl = 1'b1;
    tick();
    e++;
    check("clr_set_ovl", overload, 1);
    check("clr_set_sticky", ovl_sticky, 1);
    while (e < 260) begin
      tick();
      e++;
    end
    check("sat_ovl", overload, 1);
    check("sat_sticky", ovl_sticky, 1);
    clr_ovl = 1'b0; comp_in = 1'b0;
    tick(); tick();
    check("brk_ovl_still", overload, 1);
    tick();
    check("brk_ovl_drop", overload, 0);
    check("brk_sticky_hold", ovl_sticky, 1);
    clr_ovl = 1'b1;
    tick();
    clr_ovl = 1'b0;
    check("clr_sticky", ovl_sticky, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_modulator_frontend.md
# sd_modulator_frontend

Front end of the sigma-delta ADC, sitting directly upstream of the CIC decimation/DAC path. It synchronises the external comparator output into the adc_clk domain and drives the 1-bit feedback DAC. It supplies the bitstream and a divided decimation clock to the CIC filter, and adds bitstream monitoring: per-window ones count and an overload (stuck-bit) detector.

## Interface
- DECIM_RATIO, 64: adc_clk cycles per decimation period; even, ≥4.
- OVL_LEN, 256: consecutive identical bits that flag overload; ≥2.
- FB_INVERT, 1: 1 = fb_out is the inverse of the sampled bit.
- adc_clk  in  1  modulator sample clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run/hold control.
- comp_in  in  1  asynchronous comparator output.
- clr_ovl  in  1  clears ovl_sticky.
- sigma_delta_out  out  1  synchronised bitstream to the CIC integrators.
- fb_out  out  1  feedback DAC drive.
- decimation_clk  out  1  registered, 50% duty, period DECIM_RATIO.
- ones_count  out  $clog2(DECIM_RATIO+1)  ones in the last completed window.
- ones_valid  out  1  one-cycle strobe: ones_count updated.
- overload  out  1  current run ≥ OVL_LEN.
- ovl_sticky  out  1  latched overload.

## Operation
- Synchroniser: sync1 <= comp_in; sigma_delta_out <= sync1; fb_out <= sync1 ^ FB_INVERT. Runs regardless of enable. comp_in reaches sigma_delta_out and fb_out on the 2nd edge.
- Window counter cnt, 0..DECIM_RATIO-1, advances only when enable=1.
  - cnt_next = (cnt==DECIM_RATIO-1) ? 0 : cnt+1.
  - decimation_clk <= (cnt_next < DECIM_RATIO/2).
- Ones accumulator acc adds sigma_delta_out on every enabled cycle.
  - When enabled with cnt==DECIM_RATIO-1: ones_count <= acc + sigma_delta_out, acc <= 0, ones_valid <= 1.
  - ones_valid is 0 otherwise.
  - A window is exactly DECIM_RATIO samples; max count DECIM_RATIO with no overflow.
- Run detector, enabled cycles only:
  - Register prev <= sigma_delta_out.
  - run <= (sigma_delta_out==prev) ? min(run+1, OVL_LEN) : 1.
  - overload <= (run_next ≥ OVL_LEN).
  - The run counter saturates at OVL_LEN.
- ovl_sticky: set when overload_next=1; cleared by clr_ovl. Set wins on a simultaneous set and clear.
- enable=0 forces cnt, acc, run, prev to 0 and decimation_clk, ones_valid, overload to 0. ones_count and ovl_sticky hold. On re-enable the first cycle behaves as the first cycle after reset.

## Timing
- Reset values: every register and output is 0, including fb_out, whatever FB_INVERT is.
- Reset asserted mid-window discards the partial window. No ones_valid is produced for it.
- First enabled edge after reset: cnt=1, decimation_clk=1.
- decimation_clk rises on the edge where cnt wraps to 0. That same edge registers ones_valid=1. The CIC therefore samples at window boundaries.
- decimation_clk is high for DECIM_RATIO/2 cycles and low for DECIM_RATIO/2 cycles. It is glitch-free as a direct flop output.
- ones_valid first asserts on the DECIM_RATIO-th enabled edge.
- overload latency: asserts on the edge where the run reaches OVL_LEN. It deasserts on the first edge after a bit change.

## Structure
- Package sd_pkg: default DECIM_RATIO, OVL_LEN, and the ones_count width function. These are shared with the CIC block.
- Sub-module sd_sync2: 2-flop synchroniser with async reset. It is reused for other async inputs.

## Test plan
- comp_in=1 constant, enable=1 → sigma_delta_out=1 and fb_out=0 from the 2nd edge. ones_count=64 on every ones_valid (first valid ~1 window in). overload and ovl_sticky assert once the run reaches 256.
- comp_in toggling every cycle → ones_count=32 every 64 cycles. overload never asserts.
- Measure decimation_clk after reset release → rises at edge 1, then every 64 edges. High for 32 cycles, low for 32.
- Assert reset at cnt=40 of a window → all outputs 0 immediately. After release the next ones_valid is 64 enabled edges later with a full count.
- Drop enable for 10 cycles mid-window → decimation_clk=0, ones_valid=0, overload=0 while disabled. ones_count holds. Re-enable restarts the window at cnt=1.
- Hold clr_ovl=1 while overload is first reached → ovl_sticky=1 (set wins). A later clr_ovl with no overload → ovl_sticky=0.
